// File: rtl/fp32_div_issue.sv
// fp32_div_issue
//   Issue/collect stage in front of an iterative fp32 divider core.
//   Operand pairs arrive on a valid/ready stream and are buffered in a small
//   FIFO. They are issued one at a time to the divider with a single-cycle
//   start pulse, and the operands are held steady for the whole iteration.
//   The quotient is captured on the rising edge of div_done and presented on
//   a valid/ready output stream together with the user tag. If div_done never
//   rises, a watchdog produces a quiet-NaN error result instead.
//
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   in_valid/in_ready           operand stream handshake (ready = FIFO not full)
//   in_a, in_b, in_tag          dividend, divisor, user tag
//   div_start                   one-cycle start pulse to the divider
//   div_a, div_b                operands to the divider (change only on pop)
//   div_result, div_done        quotient and completion from the divider
//   out_valid/out_ready         result stream handshake
//   out_result, out_tag         quotient and its tag
//   out_err                     result was produced by the watchdog
//   err_count                   saturating count of watchdog events
module fp32_div_issue #(
  parameter int TAG_W    = 4,
  parameter int IN_DEPTH = 2,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_start,
  output logic [31:0]      div_a,
  output logic [31:0]      div_b,
  input  logic [31:0]      div_result,
  input  logic             div_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic [7:0]       err_count
);

  localparam int PTR_W   = $clog2(IN_DEPTH);
  localparam int CNT_W   = $clog2(TIMEOUT);
  localparam int ENTRY_W = 64 + TAG_W;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;

  // FIFO entries are packed as {tag, b, a}; pointers carry one wrap bit.
  logic [ENTRY_W-1:0] fifo_mem_r [IN_DEPTH];
  logic [PTR_W:0]     wr_ptr_r;
  logic [PTR_W:0]     rd_ptr_r;
  logic [ENTRY_W-1:0] fifo_head_s;

  logic [31:0]        op_a_r;
  logic [31:0]        op_b_r;
  logic [TAG_W-1:0]   op_tag_r;
  logic               div_start_r;
  logic [CNT_W-1:0]   wdog_r;
  logic               done_q_r;

  logic               out_valid_r;
  logic [31:0]        out_result_r;
  logic [TAG_W-1:0]   out_tag_r;
  logic               out_err_r;
  logic [7:0]         err_count_r;

  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               pop_s;
  logic               slot_free_s;
  logic               done_rise_s;
  logic               capture_s;
  logic               expire_s;

  // Occupancy and handshake decode shared by every sequential block below.
  always_comb begin
    empty_s     = (wr_ptr_r == rd_ptr_r);
    full_s      = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                  (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    push_s      = in_valid && !full_s;
    // The output slot is free now, or will be after this cycle's handshake;
    // nothing else can refill it before this op's own capture.
    slot_free_s = !out_valid_r || out_ready;
    pop_s       = (state_r == ST_IDLE) && !empty_s && slot_free_s;
    done_rise_s = div_done && !done_q_r;
    capture_s   = (state_r == ST_WAIT) && done_rise_s;
    // A done edge on the last watchdog cycle takes priority over expiry.
    expire_s    = (state_r == ST_WAIT) && !done_rise_s && (wdog_r == WDOG_LAST);
    fifo_head_s = fifo_mem_r[rd_ptr_r[PTR_W-1:0]];
  end

  // Next-state logic of the issue sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (capture_s || expire_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < IN_DEPTH; i++) begin
        fifo_mem_r[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r[PTR_W-1:0]] <= {in_tag, in_b, in_a};
        wr_ptr_r <= wr_ptr_r + (PTR_W+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (PTR_W+1)'(1);
      end
    end
  end

  // Operand registers feeding the divider, plus the start pulse that
  // coincides with the START state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_r      <= 32'd0;
      op_b_r      <= 32'd0;
      op_tag_r    <= {TAG_W{1'b0}};
      div_start_r <= 1'b0;
    end else begin
      div_start_r <= pop_s;
      if (pop_s) begin
        op_a_r   <= fifo_head_s[31:0];
        op_b_r   <= fifo_head_s[63:32];
        op_tag_r <= fifo_head_s[ENTRY_W-1:64];
      end
    end
  end

  // Watchdog: cleared in START, counts each WAIT cycle without a decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_START) begin
      wdog_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_WAIT) && !capture_s && !expire_s) begin
      wdog_r <= wdog_r + CNT_W'(1);
    end
  end

  // Previous div_done sample, kept in every state for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q_r <= 1'b0;
    end else begin
      done_q_r <= div_done;
    end
  end

  // Output slot: loaded by a capture or a watchdog expiry, emptied by the
  // consumer handshake. Loads only happen while the slot is free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_result_r <= 32'd0;
      out_tag_r    <= {TAG_W{1'b0}};
      out_err_r    <= 1'b0;
    end else if (capture_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= div_result;
      out_tag_r    <= op_tag_r;
      out_err_r    <= 1'b0;
    end else if (expire_s) begin
      out_valid_r  <= 1'b1;
      out_result_r <= QNAN;
      out_tag_r    <= op_tag_r;
      out_err_r    <= 1'b1;
    end else if (out_valid_r && out_ready) begin
      out_valid_r  <= 1'b0;
    end
  end

  // Saturating watchdog event counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_r <= 8'd0;
    end else if (expire_s && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end
  end

  assign in_ready   = !full_s;
  assign div_start  = div_start_r;
  assign div_a      = op_a_r;
  assign div_b      = op_b_r;
  assign out_valid  = out_valid_r;
  assign out_result = out_result_r;
  assign out_tag    = out_tag_r;
  assign out_err    = out_err_r;
  assign err_count  = err_count_r;

endmodule
